// File: rtl/q_matrix_pkg.sv
// q_matrix_pkg: Q4.12 types, FSM states and the transposed-Givens builder shared by q_matrix.
// Q_MATRIX_SAT_EN (see fx_mac3) selects saturating instead of wrapping arithmetic.
package q_matrix_pkg;
    localparam int SIZE = 16;
    localparam int FRAC = 12;
    typedef logic signed [SIZE-1:0] fx_t;
    localparam fx_t ONE = fx_t'(1 << FRAC);
    typedef fx_t mat3_t [3][3];
    typedef struct packed {
        fx_t s;
        fx_t c;
    } rot_t;
    typedef enum logic {IDLE, MUL1} state_t;

    // Transpose of the rotation for slot k: planes (0,1), (0,2), (1,2)
    function automatic mat3_t giv_t(input logic [1:0] k, input fx_t c, input fx_t s);
        mat3_t m;
        logic [1:0] i, j;
        i = (k == 2'd2) ? 2'd1 : 2'd0;
        j = (k == 2'd0) ? 2'd1 : 2'd2;
        for (int r = 0; r < 3; r++)
            for (int n = 0; n < 3; n++)
                m[r][n] = (r == n) ? ONE : '0;
        m[i][i] = c;
        m[j][j] = c;
        m[i][j] = -s;
        m[j][i] = s;
        return m;
    endfunction
endpackage

// File: rtl/q_matrix_if.sv
// q_matrix_if: controller-side bus of q_matrix (rotation load, start, serial Q readout).
interface q_matrix_if;
    import q_matrix_pkg::*;
    logic       start;
    logic       load;
    logic       read;
    logic [1:0] addr;
    fx_t        sin;
    fx_t        cos;
    logic       done;
    logic       finish;
    fx_t        Q;
    modport master (output start, load, read, addr, sin, cos, input done, finish, Q);
    modport slave  (input start, load, read, addr, sin, cos, output done, finish, Q);
endinterface

// File: rtl/fx_mac3.sv
// fx_mac3: Q4.12 three-term dot product, shifted by FRAC, wrapped to SIZE bits
// or clamped when Q_MATRIX_SAT_EN is defined.
module fx_mac3
    import q_matrix_pkg::*;
(
    input  fx_t a0,
    input  fx_t a1,
    input  fx_t a2,
    input  fx_t b0,
    input  fx_t b1,
    input  fx_t b2,
    output fx_t y
);
    typedef logic signed [2*SIZE+1:0] acc_t;
    acc_t sum, sh;
    always_comb begin
        sum = acc_t'(a0) * acc_t'(b0) + acc_t'(a1) * acc_t'(b1) + acc_t'(a2) * acc_t'(b2);
        sh  = sum >>> FRAC;
`ifdef Q_MATRIX_SAT_EN
        y = sh > acc_t'(2**(SIZE-1) - 1) ? fx_t'(2**(SIZE-1) - 1) :
            sh < acc_t'(-(2**(SIZE-1)))  ? fx_t'(-(2**(SIZE-1)))  : fx_t'(sh);
`else
        y = fx_t'(sh);
`endif
    end
endmodule

// File: rtl/q_matrix.sv
// q_matrix: accumulates Q = G0^T*G1^T*G2^T from three stored Givens rotations and streams it row-major.
// Q_MATRIX_SAT_EN selects saturating arithmetic in the fx_mac3 array.
module q_matrix #(
    parameter int STG  = 12,
    parameter int SIZE = 16,
    parameter int INT  = 4,
    parameter int FRAC = 12
) (
    input logic       clk,
    input logic       rst_n,
    q_matrix_if.slave bus
);
    import q_matrix_pkg::*;

    if (INT + FRAC != SIZE || SIZE != $bits(fx_t) || FRAC != q_matrix_pkg::FRAC || STG < 1) begin : g_cfg
        $error("q_matrix: parameters disagree with q_matrix_pkg");
    end

    state_t     state_q, state_d;
    rot_t       rot_q [3], rot_d [3];
    mat3_t      p_q, p_d, qm_q, qm_d, lhs, rhs, res;
    fx_t        q_q, q_d;
    fx_t        flat [9];
    logic       done_q, done_d, finish_q, finish_d;
    logic [3:0] idx_q, idx_d;

    // One 3x3 MAC array is shared: G0^T*G1^T in IDLE, P*G2^T in MUL1
    always_comb begin
        if (state_q == MUL1) begin
            lhs = p_q;
            rhs = giv_t(2'd2, rot_q[2].c, rot_q[2].s);
        end else begin
            lhs = giv_t(2'd0, rot_q[0].c, rot_q[0].s);
            rhs = giv_t(2'd1, rot_q[1].c, rot_q[1].s);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                flat[3*i+j] = qm_q[i][j];
    end

    for (genvar i = 0; i < 3; i++) begin : g_row
        for (genvar j = 0; j < 3; j++) begin : g_col
            fx_mac3 u_mac (
                .a0(lhs[i][0]), .a1(lhs[i][1]), .a2(lhs[i][2]),
                .b0(rhs[0][j]), .b1(rhs[1][j]), .b2(rhs[2][j]),
                .y (res[i][j])
            );
        end
    end

    always_comb begin
        state_d  = state_q;
        rot_d    = rot_q;
        p_d      = p_q;
        qm_d     = qm_q;
        q_d      = q_q;
        done_d   = done_q;
        finish_d = finish_q;
        idx_d    = idx_q;
        if (state_q == MUL1) begin
            qm_d    = res;
            done_d  = 1'b1;
            state_d = IDLE;
        end else if (bus.start && !bus.load) begin
            p_d     = res;
            done_d  = 1'b0;
            state_d = MUL1;
        end
        if (!bus.read) begin
            idx_d    = '0;
            finish_d = 1'b0;
        end else if (done_q) begin
            q_d      = flat[idx_q];
            idx_d    = (idx_q == 4'd8) ? idx_q : idx_q + 4'd1;
            finish_d = finish_q | (idx_q == 4'd8);
        end
        // Load wins over start and over a finish raised by the same edge
        if (bus.load) begin
            if (bus.addr != 2'd3)
                rot_d[bus.addr] = '{s: bus.sin, c: bus.cos};
            done_d   = 1'b0;
            finish_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            q_q      <= '0;
            done_q   <= 1'b0;
            finish_q <= 1'b0;
            idx_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                rot_q[i] <= '{s: '0, c: ONE};
                for (int j = 0; j < 3; j++) begin
                    p_q[i][j]  <= '0;
                    qm_q[i][j] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            rot_q    <= rot_d;
            p_q      <= p_d;
            qm_q     <= qm_d;
            q_q      <= q_d;
            done_q   <= done_d;
            finish_q <= finish_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.done   = done_q;
    assign bus.finish = finish_q;
    assign bus.Q      = q_q;
endmodule

// File: tb/tb_q_matrix.sv
// tb_q_matrix: directed and randomized checks of q_matrix against a matrix-level reference model.
// Defining Q_MATRIX_SAT_EN also enables the saturating model and the out-of-range rotation case.
module tb_q_matrix;
    typedef longint vec9_t [9];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    q_matrix_if bus();
    q_matrix #(.STG(12), .SIZE(16), .INT(4), .FRAC(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int     n_chk = 0;
    int     n_fail = 0;
    longint ms [3];
    longint mc [3];
    vec9_t  exp_q;
    longint last_q;
    const vec9_t IDENT = '{4096, 0, 0, 0, 4096, 0, 0, 0, 4096};

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint fxr(input longint v);
        longint t;
        t = v >>> 12;
`ifdef Q_MATRIX_SAT_EN
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
`else
        t = t & 64'hFFFF;
        if (t >= 32768) t -= 65536;
`endif
        return t;
    endfunction

    task automatic model_reset;
        for (int k = 0; k < 3; k++) begin
            ms[k] = 0;
            mc[k] = 4096;
        end
    endtask

    // Build each G as written (c on diagonal, +s at (i,j), -s at (j,i)) and transpose by index swap
    task automatic model_compute;
        longint g [3][3][3];
        longint p [3][3];
        longint acc;
        int pi, pj;
        for (int k = 0; k < 3; k++) begin
            pi = (k == 2) ? 1 : 0;
            pj = (k == 0) ? 1 : 2;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    g[k][r][c] = (r == c) ? 4096 : 0;
            g[k][pi][pi] = mc[k];
            g[k][pj][pj] = mc[k];
            g[k][pi][pj] = ms[k];
            g[k][pj][pi] = -ms[k];
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                acc = 0;
                for (int m = 0; m < 3; m++) acc += g[0][m][r] * g[1][c][m];
                p[r][c] = fxr(acc);
            end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                acc = 0;
                for (int m = 0; m < 3; m++) acc += p[r][m] * g[2][c][m];
                exp_q[3*r+c] = fxr(acc);
            end
    endtask

    task automatic do_load(input logic [1:0] k, input logic [15:0] s, input logic [15:0] c);
        bus.load = 1'b1;
        bus.addr = k;
        bus.sin  = s;
        bus.cos  = c;
        tick;
        bus.load = 1'b0;
        if (k != 2'd3) begin
            ms[k] = longint'($signed(s));
            mc[k] = longint'($signed(c));
        end
    endtask

    task automatic do_start;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("done_low_after_start", longint'(bus.done), 0);
        tick;
        check("done_high_2nd_edge", longint'(bus.done), 1);
    endtask

    task automatic read_all(input string tag, input vec9_t e);
        bus.read = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick;
            check($sformatf("%s_q%0d", tag, i), longint'(bus.Q), e[i]);
            check($sformatf("%s_fin%0d", tag, i), longint'(bus.finish), longint'(i == 8));
        end
        tick;
        check($sformatf("%s_hold_q", tag), longint'(bus.Q), e[8]);
        check($sformatf("%s_hold_fin", tag), longint'(bus.finish), 1);
        bus.read = 1'b0;
        tick;
        check($sformatf("%s_fin_clr", tag), longint'(bus.finish), 0);
        check($sformatf("%s_q_kept", tag), longint'(bus.Q), e[8]);
        last_q = e[8];
    endtask

    initial begin
        logic [15:0] rs, rc;
        bus.start = 1'b0;
        bus.load  = 1'b0;
        bus.read  = 1'b0;
        bus.addr  = 2'd0;
        bus.sin   = '0;
        bus.cos   = '0;
        model_reset;
        repeat (3) tick;
        check("rst_done", longint'(bus.done), 0);
        check("rst_finish", longint'(bus.finish), 0);
        check("rst_q", longint'(bus.Q), 0);
        rst_n = 1'b1;
        tick;

        do_start;
        read_all("ident", IDENT);

        do_load(2'd0, 16'h0B50, 16'h0B50);
        do_start;
        read_all("rot45", '{2896, -2896, 0, 2896, 2896, 0, 0, 0, 4096});

        do_load(2'd0, 16'h0000, 16'h1000);
        do_load(2'd2, 16'h1000, 16'h0000);
        do_start;
        read_all("rot90", '{4096, 0, 0, 0, 0, -4096, 0, 4096, 0});

        check("done_before_load", longint'(bus.done), 1);
        do_load(2'd1, 16'h0800, 16'h0DDB);
        check("done_cleared_by_load", longint'(bus.done), 0);
        bus.read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check($sformatf("nodone_q%0d", i), longint'(bus.Q), last_q);
            check($sformatf("nodone_fin%0d", i), longint'(bus.finish), 0);
        end
        bus.read = 1'b0;
        tick;

        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 1) == 1) begin
                        rs = 16'($urandom_range(0, 8192)) - 16'd4096;
                        rc = 16'($urandom_range(0, 8192)) - 16'd4096;
                    end else begin
                        rs = 16'($urandom);
                        rc = 16'($urandom);
                    end
                    do_load(2'(k), rs, rc);
                end
            if ($urandom_range(0, 3) == 0) do_load(2'd3, 16'($urandom), 16'($urandom));
            model_compute;
            do_start;
            read_all($sformatf("rnd%0d", it), exp_q);
        end

`ifdef Q_MATRIX_SAT_EN
        for (int k = 0; k < 3; k++) do_load(2'(k), 16'h7FFF, 16'h7FFF);
        model_compute;
        do_start;
        read_all("sat", exp_q);
`endif

        do_load(2'd1, 16'h0B50, 16'h0B50);
        do_start;
        bus.read = 1'b1;
        repeat (4) tick;
        #2 rst_n = 1'b0;
        #1;
        check("midrd_rst_done", longint'(bus.done), 0);
        check("midrd_rst_finish", longint'(bus.finish), 0);
        check("midrd_rst_q", longint'(bus.Q), 0);
        bus.read = 1'b0;
        model_reset;
        tick;
        rst_n = 1'b1;
        tick;
        do_start;
        read_all("post_rst", IDENT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/q_matrix.md
Name: q_matrix

Overview:
- Accumulates the orthogonal Q factor of a 3x3 QR decomposition from three Givens rotations.
- Each rotation is supplied as a (sin, cos) pair, typically from an upstream CORDIC.
- Sits after the rotation-angle generator; an external controller loads the three rotations, pulses `start`, then streams out Q serially.
- Fixed-point format is signed Q4.12.

Parameters:
- STG, 12: CORDIC stage count of the upstream generator. Carried for interface compatibility; no internal effect.
- SIZE, 16: total word width of sin, cos and Q.
- INT, 4: integer bits including sign (INT + FRAC = SIZE).
- FRAC, 12: fractional bits; 1.0 = 1 << FRAC = 0x1000.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled request to compute Q from stored rotations.
- load  in  1  write sin/cos into rotation slot addr.
- read  in  1  level; stream Q elements while high.
- addr  in  2  rotation slot select (0..2; 3 ignored).
- sin  in  SIZE  signed Q4.12 sine of rotation.
- cos  in  SIZE  signed Q4.12 cosine of rotation.
- done  out  1  Q valid (sticky).
- finish  out  1  all 9 elements streamed.
- Q  out  SIZE  signed Q4.12 current streamed element.

Behaviour:
- Single clock. Reset is asynchronous and active-low; all state is cleared on rst_n low regardless of clk.
- Reset values:
  - done = 0, finish = 0, Q = 0, read index = 0, FSM = IDLE.
  - Rotation slots reset to identity: cos = 0x1000, sin = 0.
  - Q-matrix registers reset to 0.
- Rotation matrix for slot k acts in plane (i,j): slot 0 = (0,1), slot 1 = (0,2), slot 2 = (1,2).
  - G[i][i] = G[j][j] = c; G[i][j] = s; G[j][i] = -s; other entries are identity.
- Result: Q = G0^T · G1^T · G2^T.
- Load:
  - When load = 1 on an edge and addr < 3, the slot is written with {sin, cos}.
  - addr = 3 is ignored.
  - Load also clears done and finish.
  - Load has priority over start on the same edge.
- FSM: IDLE → MUL1 → IDLE.
  - IDLE: if start = 1 and load = 0 at edge E, then P <= G0^T·G1^T, go to MUL1, clear done.
  - MUL1: at edge E+1, Qm <= P·G2^T, done <= 1, return to IDLE.
  - done is therefore visible after E+1 and holds until the next load or start.
  - start sampled while in MUL1 is ignored.
- Arithmetic (per element):
  - Products are full 2·SIZE bits; sum of up to 3 products in 2·SIZE+2 bits.
  - The sum is arithmetically shifted right by FRAC (truncation toward -inf).
  - Low SIZE bits are kept (wrap).
  - P is stored at SIZE width with the same rule.
- Read:
  - While read = 1 and done = 1, each edge drives Q <= Qm[idx], row-major idx 0..8, then idx increments.
  - On the edge presenting idx 8, finish <= 1. Q holds element 8 and finish stays high while read stays high.
  - read = 0: idx <= 0, finish <= 0, Q holds its last value.
  - read while done = 0: ignored (Q, idx, finish unchanged).
- Reset mid-read or mid-compute returns everything to reset values; rotations return to identity.

Optional Feature:
- Q_MATRIX_SAT_EN defined: every shifted sum is saturated to [-2^(SIZE-1), 2^(SIZE-1)-1] before storing.
- Undefined: wrap (low SIZE bits).

Decomposition:
- Package q_matrix_pkg holds:
  - SIZE/FRAC localparams.
  - typedef fx_t (logic signed [SIZE-1:0]).
  - ONE constant (0x1000).
  - typedef mat3_t (fx_t [3][3]).
  - FSM state enum.
- One sub-module, fx_mac3: signed 3-term multiply-accumulate with shift and wrap/saturate. Instantiated per matrix element.

Test Plan:
- Reset, no load, pulse start → done = 1 two edges after start is applied; read streams 0x1000,0,0,0,0x1000,0,0,0,0x1000; finish = 1 by the 10th edge.
- Load slot0 c = s = 0x0B50, slots 1–2 identity, start, read → 0x0B50, 0xF4B0, 0, 0x0B50, 0x0B50, 0, 0, 0, 0x1000.
- Load slot2 c = 0, s = 0x1000 (90°), others identity → rows [1,0,0], [0,0,-1], [0,1,0] (0xF000 at idx 5, 0x1000 at idx 7).
- After done = 1, pulse load on any slot → done = 0 next edge; read while done = 0 → Q stays constant, finish = 0.
- Assert rst_n low mid-read (after 4 elements) → done, finish, Q = 0 immediately; a subsequent start yields the identity Q.
- With Q_MATRIX_SAT_EN defined, load c = s = 0x7FFF on all slots (out-of-range values) → no Q element wraps sign; all are clamped to 0x7FFF/0x8000.
